// File: rtl/multicycle_alu.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_alu
// Description : Handshaked accumulator-datapath ALU. Logic, add/sub, shift
//               and compare ops complete in one cycle. MUL (shift-add) and
//               DIV (restoring) iterate WIDTH cycles and return a full-width
//               high word. Results and status flags are held until the
//               consumer takes them.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_alu #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             flag_zero,
    output logic             flag_carry,
    output logic             flag_overflow,
    output logic             flag_div0
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_MUL  = 2'd1;
    localparam logic [1:0] c_DIV  = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    localparam logic [3:0] c_OP_ADD  = 4'h0;
    localparam logic [3:0] c_OP_SUB  = 4'h1;
    localparam logic [3:0] c_OP_MUL  = 4'h2;
    localparam logic [3:0] c_OP_DIV  = 4'h3;
    localparam logic [3:0] c_OP_SHL  = 4'h4;
    localparam logic [3:0] c_OP_SHR  = 4'h5;
    localparam logic [3:0] c_OP_ROL  = 4'h6;
    localparam logic [3:0] c_OP_ROR  = 4'h7;
    localparam logic [3:0] c_OP_AND  = 4'h8;
    localparam logic [3:0] c_OP_OR   = 4'h9;
    localparam logic [3:0] c_OP_XOR  = 4'hA;
    localparam logic [3:0] c_OP_NOR  = 4'hB;
    localparam logic [3:0] c_OP_NAND = 4'hC;
    localparam logic [3:0] c_OP_XNOR = 4'hD;
    localparam logic [3:0] c_OP_GT   = 4'hE;
    localparam logic [3:0] c_OP_EQ   = 4'hF;

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_hi;     // partial product high / partial remainder
    logic [WIDTH-1:0] r_lo;     // multiplier shifting out / quotient shifting in
    logic [WIDTH-1:0] r_b;      // latched multiplicand / divisor

    logic             w_accept;
    logic             w_last;
    logic             w_div0;
    logic             w_single;

    // Single-cycle datapath
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH:0]   w_shl;
    logic [WIDTH:0]   w_shr;
    logic [WIDTH-1:0] w_rol;
    logic [WIDTH-1:0] w_ror;
    logic [SHAMT_W-1:0] w_n;
    logic [SHAMT_W-1:0] w_rot_n;
    logic [WIDTH-1:0] w_res;
    logic             w_carry;
    logic             w_ovf;

    // Iterative datapath, next-step values
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH-1:0] w_mul_hi_nx;
    logic [WIDTH-1:0] w_mul_lo_nx;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_rem_sub;
    logic             w_q_bit;
    logic [WIDTH-1:0] w_div_hi_nx;
    logic [WIDTH-1:0] w_div_lo_nx;

    // Ready is forced low while reset is asserted so no output reads 1 in reset.
    assign in_ready  = (r_state == c_IDLE) & reset_n;
    assign out_valid = (r_state == c_DONE);

    assign w_accept = in_valid && (r_state == c_IDLE);
    assign w_last   = (r_cnt == c_LAST);
    assign w_div0   = (opcode == c_OP_DIV) && (operand2 == '0);
    assign w_single = (opcode != c_OP_MUL) && (opcode != c_OP_DIV);

    assign w_sum   = {1'b0, operand1} + {1'b0, operand2};
    assign w_diff  = {1'b0, operand1} - {1'b0, operand2};
    assign w_n     = operand2[SHAMT_W-1:0];
    assign w_rot_n = SHAMT_W'(int'(w_n) % WIDTH);
    // Extra bit on the shifted-out side captures the last bit that left.
    assign w_shl   = {1'b0, operand1} << w_n;
    assign w_shr   = {operand1, 1'b0} >> w_n;
    // A shift by WIDTH yields zero, so a zero rotate reduces to pass-through.
    assign w_rol   = (operand1 << w_rot_n) | (operand1 >> (WIDTH - int'(w_rot_n)));
    assign w_ror   = (operand1 >> w_rot_n) | (operand1 << (WIDTH - int'(w_rot_n)));

    // Shift-add step: add multiplicand when the multiplier LSB is set, then shift right.
    assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    assign w_mul_hi_nx = w_mul_sum[WIDTH:1];
    assign w_mul_lo_nx = {w_mul_sum[0], r_lo[WIDTH-1:1]};

    // Restoring step: bring down next dividend bit, keep the subtraction if no borrow.
    assign w_rem_sh    = {r_hi, r_lo[WIDTH-1]};
    assign w_rem_sub   = w_rem_sh - {1'b0, r_b};
    assign w_q_bit     = ~w_rem_sub[WIDTH];
    assign w_div_hi_nx = w_q_bit ? w_rem_sub[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
    assign w_div_lo_nx = {r_lo[WIDTH-2:0], w_q_bit};

    // Single-cycle result and flag selection by opcode
    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (opcode)
            c_OP_ADD: begin
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = (operand1[WIDTH-1] == operand2[WIDTH-1]) &&
                          (w_sum[WIDTH-1] != operand1[WIDTH-1]);
            end
            c_OP_SUB: begin
                w_res   = w_diff[WIDTH-1:0];
                w_carry = w_diff[WIDTH];
                w_ovf   = (operand1[WIDTH-1] != operand2[WIDTH-1]) &&
                          (w_diff[WIDTH-1] != operand1[WIDTH-1]);
            end
            c_OP_SHL: begin
                w_res   = w_shl[WIDTH-1:0];
                w_carry = w_shl[WIDTH];
            end
            c_OP_SHR: begin
                w_res   = w_shr[WIDTH:1];
                w_carry = w_shr[0];
            end
            c_OP_ROL:  w_res = w_rol;
            c_OP_ROR:  w_res = w_ror;
            c_OP_AND:  w_res = operand1 & operand2;
            c_OP_OR:   w_res = operand1 | operand2;
            c_OP_XOR:  w_res = operand1 ^ operand2;
            c_OP_NOR:  w_res = ~(operand1 | operand2);
            c_OP_NAND: w_res = ~(operand1 & operand2);
            c_OP_XNOR: w_res = ~(operand1 ^ operand2);
            c_OP_GT:   w_res = {{(WIDTH-1){1'b0}}, (operand1 > operand2)};
            c_OP_EQ:   w_res = {{(WIDTH-1){1'b0}}, (operand1 == operand2)};
            default:   w_res = '0;
        endcase
    end

    // Control FSM and iterative MUL/DIV working registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_b     <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_b   <= operand2;
                        r_hi  <= '0;
                        r_lo  <= operand1;
                        r_cnt <= '0;
                        if (opcode == c_OP_MUL) begin
                            r_state <= c_MUL;
                        end else if ((opcode == c_OP_DIV) && !w_div0) begin
                            r_state <= c_DIV;
                        end else begin
                            r_state <= c_DONE;
                        end
                    end
                end
                c_MUL: begin
                    r_hi  <= w_mul_hi_nx;
                    r_lo  <= w_mul_lo_nx;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_state <= c_DONE;
                    end
                end
                c_DIV: begin
                    r_hi  <= w_div_hi_nx;
                    r_lo  <= w_div_lo_nx;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_state <= c_DONE;
                    end
                end
                c_DONE: begin
                    if (out_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Result/flag registers: loaded once when the operation completes, then held
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result        <= '0;
            result_hi     <= '0;
            flag_zero     <= 1'b0;
            flag_carry    <= 1'b0;
            flag_overflow <= 1'b0;
            flag_div0     <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept && w_div0) begin
                        result        <= '1;
                        result_hi     <= operand1;
                        flag_zero     <= 1'b0;
                        flag_carry    <= 1'b0;
                        flag_overflow <= 1'b0;
                        flag_div0     <= 1'b1;
                    end else if (w_accept && w_single) begin
                        result        <= w_res;
                        result_hi     <= '0;
                        flag_zero     <= (w_res == '0);
                        flag_carry    <= w_carry;
                        flag_overflow <= w_ovf;
                        flag_div0     <= 1'b0;
                    end
                end
                c_MUL: begin
                    if (w_last) begin
                        result        <= w_mul_lo_nx;
                        result_hi     <= w_mul_hi_nx;
                        flag_zero     <= (w_mul_lo_nx == '0);
                        flag_carry    <= (w_mul_hi_nx != '0);
                        flag_overflow <= 1'b0;
                        flag_div0     <= 1'b0;
                    end
                end
                c_DIV: begin
                    if (w_last) begin
                        result        <= w_div_lo_nx;
                        result_hi     <= w_div_hi_nx;
                        flag_zero     <= (w_div_lo_nx == '0);
                        flag_carry    <= 1'b0;
                        flag_overflow <= 1'b0;
                        flag_div0     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_alu
// Description : Self-checking bench for multicycle_alu (WIDTH=16): directed
//               vectors, randomized ops against an arithmetic reference,
//               backpressure and mid-operation reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_alu;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    opcode = 4'h0;
    logic [W-1:0]  operand1 = '0;
    logic [W-1:0]  operand2 = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  result;
    logic [W-1:0]  result_hi;
    logic          flag_zero;
    logic          flag_carry;
    logic          flag_overflow;
    logic          flag_div0;

    int n_checks = 0;
    int n_fail   = 0;

    multicycle_alu #(.WIDTH(W)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .opcode        (opcode),
        .operand1      (operand1),
        .operand2      (operand2),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .result        (result),
        .result_hi     (result_hi),
        .flag_zero     (flag_zero),
        .flag_carry    (flag_carry),
        .flag_overflow (flag_overflow),
        .flag_div0     (flag_div0)
    );

    always #5 clk = ~clk;

    // Packed observation: {result, result_hi, zero, carry, overflow, div0}
    function automatic logic [35:0] observed();
        return {result, result_hi, flag_zero, flag_carry, flag_overflow, flag_div0};
    endfunction

    function automatic int to_signed16(input int v);
        return (v >= 32768) ? v - 65536 : v;
    endfunction

    // Reference model written from the operation definitions using integer arithmetic
    function automatic logic [35:0] model(input logic [3:0] op, input logic [15:0] a16,
                                          input logic [15:0] b16);
        int a, b, n, res, hi, c, v, d, s;
        longint p;
        a = int'(a16); b = int'(b16);
        n = b % 16;
        res = 0; hi = 0; c = 0; v = 0; d = 0;
        case (op)
            4'h0: begin
                res = (a + b) & 'hFFFF; c = (a + b) >> 16;
                s = to_signed16(a) + to_signed16(b); v = (s > 32767 || s < -32768) ? 1 : 0;
            end
            4'h1: begin
                res = (a - b) & 'hFFFF; c = (a < b) ? 1 : 0;
                s = to_signed16(a) - to_signed16(b); v = (s > 32767 || s < -32768) ? 1 : 0;
            end
            4'h2: begin
                p = longint'(a) * longint'(b);
                res = int'(p & 'hFFFF); hi = int'(p >> 16); c = (hi != 0) ? 1 : 0;
            end
            4'h3: begin
                if (b == 0) begin res = 'hFFFF; hi = a; d = 1; end
                else begin res = a / b; hi = a % b; end
            end
            4'h4: begin res = (a << n) & 'hFFFF; c = (n == 0) ? 0 : (a >> (16 - n)) & 1; end
            4'h5: begin res = a >> n; c = (n == 0) ? 0 : (a >> (n - 1)) & 1; end
            4'h6: res = ((a << n) | (a >> (16 - n))) & 'hFFFF;
            4'h7: res = ((a >> n) | (a << (16 - n))) & 'hFFFF;
            4'h8: res = a & b;
            4'h9: res = a | b;
            4'hA: res = a ^ b;
            4'hB: res = ~(a | b) & 'hFFFF;
            4'hC: res = ~(a & b) & 'hFFFF;
            4'hD: res = ~(a ^ b) & 'hFFFF;
            4'hE: res = (a > b) ? 1 : 0;
            default: res = (a == b) ? 1 : 0;
        endcase
        return {16'(res), 16'(hi), (res == 0), 1'(c), 1'(v), 1'(d)};
    endfunction

    function automatic int model_latency(input logic [3:0] op, input logic [15:0] b16);
        if (op == 4'h2) return 17;
        if (op == 4'h3 && b16 != 16'h0) return 17;
        return 1;
    endfunction

    // Issue one op, measure edges until out_valid, capture outputs, then consume.
    // Entered and left #1 after a rising edge.
    task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          input int hold, output int lat, output logic [35:0] got);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        in_valid = 1'b1; opcode = op; operand1 = a; operand2 = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        opcode = 4'($urandom); operand1 = 16'($urandom); operand2 = 16'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        got = observed();
        repeat (hold) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({observed(), out_valid} !== 37'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h out_valid=%b, want all zero", observed(), out_valid);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        logic [3:0]  ops  [7];
        logic [15:0] as   [7];
        logic [15:0] bs   [7];
        logic [35:0] exps [7];
        int          lats [7];
        int          lat;
        logic [35:0] got;
        ops[0] = 4'h0; as[0] = 16'hFFFF; bs[0] = 16'h0001; exps[0] = {16'h0000, 16'h0000, 4'b1100}; lats[0] = 1;
        ops[1] = 4'h1; as[1] = 16'h8000; bs[1] = 16'h0001; exps[1] = {16'h7FFF, 16'h0000, 4'b0010}; lats[1] = 1;
        ops[2] = 4'h6; as[2] = 16'h8001; bs[2] = 16'h0001; exps[2] = {16'h0003, 16'h0000, 4'b0000}; lats[2] = 1;
        ops[3] = 4'h5; as[3] = 16'h0003; bs[3] = 16'h0001; exps[3] = {16'h0001, 16'h0000, 4'b0100}; lats[3] = 1;
        ops[4] = 4'h2; as[4] = 16'h1234; bs[4] = 16'h0100; exps[4] = {16'h3400, 16'h0012, 4'b0100}; lats[4] = 17;
        ops[5] = 4'h3; as[5] = 16'd100;  bs[5] = 16'd7;    exps[5] = {16'd14,   16'd2,    4'b0000}; lats[5] = 17;
        ops[6] = 4'h3; as[6] = 16'h0055; bs[6] = 16'h0000; exps[6] = {16'hFFFF, 16'h0055, 4'b0001}; lats[6] = 1;
        for (int i = 0; i < 7; i++) begin
            run_op(ops[i], as[i], bs[i], 0, lat, got);
            n_checks++;
            if (got !== exps[i]) begin
                n_fail++;
                $display("FAIL directed_%0d_value: op=%h got %h, want %h", i, ops[i], got, exps[i]);
            end
            n_checks++;
            if (lat !== lats[i]) begin
                n_fail++;
                $display("FAIL directed_%0d_latency: op=%h got %0d, want %0d", i, ops[i], lat, lats[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0]  op;
        logic [15:0] a, b;
        logic [35:0] got, exp;
        int          lat;
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = 16'($urandom);
            b  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 17)) : 16'($urandom);
            exp = model(op, a, b);
            run_op(op, a, b, $urandom_range(0, 2), lat, got);
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL random_%0d_value: op=%h a=%h b=%h got %h, want %h", i, op, a, b, got, exp);
            end
            n_checks++;
            if (lat !== model_latency(op, b)) begin
                n_fail++;
                $display("FAIL random_%0d_latency: op=%h b=%h got %0d, want %0d",
                         i, op, b, lat, model_latency(op, b));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [35:0] snap;
        int          guard;
        in_valid = 1'b1; opcode = 4'hA; operand1 = 16'hA5A5; operand2 = 16'h0F0F;
        @(posedge clk); #1;
        // Next request presented immediately and held while the result waits
        opcode = 4'h0; operand1 = 16'd2; operand2 = 16'd9;
        guard = 0;
        while (!out_valid && guard < 50) begin @(posedge clk); #1; guard++; end
        snap = observed();
        n_checks++;
        if (snap !== model(4'hA, 16'hA5A5, 16'h0F0F)) begin
            n_fail++;
            $display("FAIL bp_first_value: got %h, want %h", snap, model(4'hA, 16'hA5A5, 16'h0F0F));
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({observed(), out_valid, in_ready} !== {snap, 2'b10}) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: got %h v=%b r=%b, want %h v=1 r=0",
                         i, observed(), out_valid, in_ready, snap);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, result} !== {1'b1, 16'd11}) begin
            n_fail++;
            $display("FAIL bp_next_accept: out_valid=%b result=%h, want 1 000b", out_valid, result);
        end
        // Leave the 2+9 result in the output registers for the reset test
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_div();
        int          lat;
        logic [35:0] got;
        in_valid = 1'b1; opcode = 4'h3; operand1 = 16'd1000; operand2 = 16'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({observed(), out_valid} !== 37'h0) begin
            n_fail++;
            $display("FAIL mid_div_reset: got %h out_valid=%b, want all zero", observed(), out_valid);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL mid_div_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
        run_op(4'h0, 16'd2, 16'd3, 0, lat, got);
        n_checks++;
        if ({got, lat[7:0]} !== {16'd5, 16'd0, 4'b0000, 8'd1}) begin
            n_fail++;
            $display("FAIL post_reset_add: got %h lat=%0d, want 00050000 0 lat=1", got, lat);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_div();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
